// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types for the memory port arbiter: FSM state encoding, requester
//   identifiers and the request operation encoding, plus a helper that turns
//   a requester's read/write levels into one operation.
//   No ports (package).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_t;

  localparam int DEF_ADDR_W  = 28;
  localparam int DEF_DATA_W  = 128;
  localparam int DEF_TIMEOUT = 1023;

  // A requester raising read and write together is asking for a write.
  function automatic op_t decodeOp(input logic rd, input logic wr);
    op_t op;
    op = OP_NONE;
    if (wr)
      op = OP_WRITE;
    else if (rd)
      op = OP_READ;
    return op;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//   Combinational winner select between the I-cache and D-cache requesters.
//   Configuration macro: MEM_ARB_RR_EN
//     defined   -> round-robin on a tie (winner is the side not granted last)
//     undefined -> fixed priority, D-cache wins a tie
//   A lone requester is always granted.
// Ports
//   i_iReq       in   I-cache has read or write pending
//   i_dReq       in   D-cache has read or write pending
//   i_lastGrant  in   requester granted most recently
//   o_valid      out  at least one requester pending
//   o_winner     out  selected requester (meaningful when o_valid)
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic    i_iReq,
  input  logic    i_dReq,
  input  req_id_t i_lastGrant,
  output logic    o_valid,
  output req_id_t o_winner
);

`ifndef MEM_ARB_RR_EN
  // Fixed priority has no use for the grant history.
  logic w_unusedLastGrant;
  assign w_unusedLastGrant = i_lastGrant;
`endif

  always_comb begin
    o_valid  = i_iReq | i_dReq;
    o_winner = REQ_D;
    if (i_iReq && !i_dReq) begin
      o_winner = REQ_I;
    end else if (i_dReq && !i_iReq) begin
      o_winner = REQ_D;
    end else if (i_iReq && i_dReq) begin
`ifdef MEM_ARB_RR_EN
      o_winner = (i_lastGrant == REQ_I) ? REQ_D : REQ_I;
`else
      o_winner = REQ_D;
`endif
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one slow-memory line port between the I-cache and D-cache. One
//   access is forwarded at a time: IDLE latches the winner's request, BUSY
//   holds it on the memory port until mem_ready, RESP gives the winner a
//   one-cycle ready pulse with registered read data. A saturating watchdog
//   counts BUSY cycles and sets a sticky timeout flag (TIMEOUT=0 disables it).
//   Configuration macro: MEM_ARB_RR_EN (round-robin tie break, see mem_arb_pick).
// Ports
//   clk, rst_n                        clock, async active-low reset
//   i_read/i_write/i_addr/i_wdata     I-cache request (levels, held until i_ready)
//   i_rdata/i_ready                   I-cache read line and completion pulse
//   d_read/d_write/d_addr/d_wdata     D-cache request
//   d_rdata/d_ready                   D-cache read line and completion pulse
//   mem_read/mem_write/mem_addr/mem_wdata   to slow memory
//   mem_rdata/mem_ready               from slow memory
//   timeout_err                       sticky watchdog flag
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              timeout_err
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t            r_state;
  state_t            w_nextState;
  req_id_t           r_winner;
  req_id_t           r_lastGrant;
  logic              r_memRead;
  logic              r_memWrite;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;
  logic [DATA_W-1:0] r_iRdata;
  logic [DATA_W-1:0] r_dRdata;
  logic              r_iReady;
  logic              r_dReady;
  logic [CNT_W-1:0]  r_waitCnt;
  logic              r_timeoutErr;

  logic              w_valid;
  req_id_t           w_winner;
  op_t               w_selOp;
  logic [ADDR_W-1:0] w_selAddr;
  logic [DATA_W-1:0] w_selWdata;

  mem_arb_pick u_pick (
    .i_iReq      (i_read | i_write),
    .i_dReq      (d_read | d_write),
    .i_lastGrant (r_lastGrant),
    .o_valid     (w_valid),
    .o_winner    (w_winner)
  );

  always_comb begin
    w_selOp    = OP_NONE;
    w_selAddr  = i_addr;
    w_selWdata = i_wdata;
    if (w_winner == REQ_D) begin
      w_selOp    = decodeOp(d_read, d_write);
      w_selAddr  = d_addr;
      w_selWdata = d_wdata;
    end else begin
      w_selOp    = decodeOp(i_read, i_write);
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (w_valid)   w_nextState = ST_BUSY;
      ST_BUSY: if (mem_ready) w_nextState = ST_RESP;
      ST_RESP: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_nextState;
  end

  // Ready pulses default low every cycle, so a pulse set on the BUSY->RESP
  // edge lasts exactly the RESP cycle. mem_ready is only looked at in BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_winner     <= REQ_I;
      r_lastGrant  <= REQ_I;
      r_memRead    <= 1'b0;
      r_memWrite   <= 1'b0;
      r_memAddr    <= '0;
      r_memWdata   <= '0;
      r_iRdata     <= '0;
      r_dRdata     <= '0;
      r_iReady     <= 1'b0;
      r_dReady     <= 1'b0;
      r_waitCnt    <= '0;
      r_timeoutErr <= 1'b0;
    end else begin
      r_iReady <= 1'b0;
      r_dReady <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_winner    <= w_winner;
            r_lastGrant <= w_winner;
            r_memRead   <= (w_selOp == OP_READ);
            r_memWrite  <= (w_selOp == OP_WRITE);
            r_memAddr   <= w_selAddr;
            r_memWdata  <= w_selWdata;
            r_waitCnt   <= '0;
          end
        end
        ST_BUSY: begin
          if (r_waitCnt != CNT_MAX)
            r_waitCnt <= r_waitCnt + 1'b1;
          if (TIMEOUT != 0 && r_waitCnt == CNT_MAX - 1'b1)
            r_timeoutErr <= 1'b1;
          if (mem_ready) begin
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            if (r_winner == REQ_D) begin
              r_dReady <= 1'b1;
              if (r_memRead)
                r_dRdata <= mem_rdata;
            end else begin
              r_iReady <= 1'b1;
              if (r_memRead)
                r_iRdata <= mem_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_read    = r_memRead;
  assign mem_write   = r_memWrite;
  assign mem_addr    = r_memAddr;
  assign mem_wdata   = r_memWdata;
  assign i_rdata     = r_iRdata;
  assign d_rdata     = r_dRdata;
  assign i_ready     = r_iReady;
  assign d_ready     = r_dReady;
  assign timeout_err = r_timeoutErr;

endmodule
